// File: rtl/mem_alu_seq_pkg.sv
// Shared types and constants for the load/compute/store sequencer.
package mem_alu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_WAIT,
    EXEC,
    WR,
    DONE
  } state_t;

  localparam logic [1:0] FN_ADD = 2'd0;
  localparam logic [1:0] FN_SUB = 2'd1;
  localparam logic [1:0] FN_AND = 2'd2;
  localparam logic [1:0] FN_XOR = 2'd3;

  // op_mode layout: [2] selects rotating function, [1:0] is the base function
  localparam int unsigned OPM_ROT    = 2;
  localparam int unsigned OPM_FN_LSB = 0;

endpackage

// File: rtl/mem_seq_alu.sv
// Combinational 4-function ALU; flag is carry-out (ADD) or borrow (SUB), else 0.
module mem_seq_alu
  import mem_alu_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        func,
  output logic [DATA_W-1:0] y,
  output logic              flag
);

  always_comb begin
    y    = '0;
    flag = 1'b0;
    case (func)
      FN_ADD:  {flag, y} = {1'b0, a} + {1'b0, b};
      FN_SUB:  {flag, y} = {1'b0, a} - {1'b0, b};
      FN_AND:  y = a & b;
      default: y = a ^ b;
    endcase
  end

endmodule

// File: rtl/mem_alu_sequencer.sv
// Loads 2*N_OPS words from SRAM, combines each pair through the ALU and writes
// the results back starting at dst_base. All reads finish before the first write.
module mem_alu_sequencer
  import mem_alu_seq_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned N_OPS    = 3,
  parameter int unsigned SRAM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [2:0]        op_mode,
  output logic              sram_ce,
  output logic              sram_oe,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  localparam int unsigned NW = 2 * N_OPS;
  localparam int unsigned IW = $clog2(NW);
  localparam int unsigned CW = $clog2(NW + 1);
  localparam int unsigned KW = $clog2(N_OPS + 1);
  localparam int unsigned LW = (SRAM_LAT > 1) ? $clog2(SRAM_LAT) : 1;

  state_t              state;
  logic [CW-1:0]       i_q;
  logic [KW-1:0]       k_q;
  logic [LW-1:0]       wait_q;
  logic [ADDR_W-1:0]   src_q;
  logic [ADDR_W-1:0]   dst_q;
  logic [2:0]          op_q;
  logic [DATA_W-1:0]   rf [NW];

  logic                last_wait;
  logic [1:0]          fn;
  logic [DATA_W-1:0]   alu_y;
  logic                alu_flag;

  assign last_wait = (wait_q == LW'(SRAM_LAT - 1));
  assign fn = op_q[OPM_ROT] ? (op_q[OPM_FN_LSB +: 2] + 2'(k_q)) : op_q[OPM_FN_LSB +: 2];

  mem_seq_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a    (rf[IW'({k_q, 1'b0})]),
    .b    (rf[IW'({k_q, 1'b1})]),
    .func (fn),
    .y    (alu_y),
    .flag (alu_flag)
  );

  // Register file is data-only storage and deliberately left unreset.
  always_ff @(posedge clk) begin
    if (state == RD_WAIT && last_wait) begin
      rf[i_q[IW-1:0]] <= sram_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      i_q        <= '0;
      k_q        <= '0;
      wait_q     <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      op_q       <= '0;
      sram_ce    <= 1'b0;
      sram_oe    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      // Strobes and done are single-cycle; each transition re-asserts what it needs.
      sram_ce <= 1'b0;
      sram_oe <= 1'b0;
      sram_we <= 1'b0;
      done    <= 1'b0;
      if (state != IDLE && abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              src_q     <= src_base;
              dst_q     <= dst_base;
              op_q      <= op_mode;
              ovf       <= 1'b0;
              i_q       <= '0;
              k_q       <= '0;
              busy      <= 1'b1;
              sram_ce   <= 1'b1;
              sram_oe   <= 1'b1;
              sram_addr <= src_base;
              state     <= RD;
            end
          end
          RD: begin
            wait_q <= '0;
            state  <= RD_WAIT;
          end
          RD_WAIT: begin
            if (last_wait) begin
              i_q <= i_q + CW'(1);
              if (i_q == CW'(NW - 1)) begin
                state <= EXEC;
              end else begin
                sram_ce   <= 1'b1;
                sram_oe   <= 1'b1;
                sram_addr <= src_q + ADDR_W'(i_q + CW'(1));
                state     <= RD;
              end
            end else begin
              wait_q <= wait_q + LW'(1);
            end
          end
          EXEC: begin
            sram_wdata <= alu_y;
            ovf        <= ovf | alu_flag;
            sram_ce    <= 1'b1;
            sram_we    <= 1'b1;
            sram_addr  <= dst_q + ADDR_W'(k_q);
            state      <= WR;
          end
          WR: begin
            k_q <= k_q + KW'(1);
            if (k_q == KW'(N_OPS - 1)) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= EXEC;
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_alu_sequencer.sv
// Directed bench: two sequencer instances (default and SRAM_LAT=3/N_OPS=4) on SRAM models.
module tb_mem_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  always #5 clk = ~clk;

  logic       start, abort;
  logic [4:0] src_base, dst_base, sram_addr;
  logic [2:0] op_mode;
  logic       sram_ce, sram_oe, sram_we, busy, done, ovf;
  logic [7:0] sram_wdata, sram_rdata;

  logic       s2_start;
  logic [4:0] s2_src, s2_dst, s2_addr;
  logic [2:0] s2_mode;
  logic       s2_ce, s2_oe, s2_we, s2_busy, s2_done, s2_ovf;
  logic [7:0] s2_wdata, s2_rdata;

  logic       tb_we;
  logic [4:0] tb_a;
  logic [7:0] tb_d;

  mem_alu_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .src_base(src_base), .dst_base(dst_base), .op_mode(op_mode),
    .sram_ce(sram_ce), .sram_oe(sram_oe), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .busy(busy), .done(done), .ovf(ovf)
  );

  mem_alu_sequencer #(.DATA_W(8), .ADDR_W(5), .N_OPS(4), .SRAM_LAT(3)) dut2 (
    .clk(clk), .reset(reset), .start(s2_start), .abort(1'b0),
    .src_base(s2_src), .dst_base(s2_dst), .op_mode(s2_mode),
    .sram_ce(s2_ce), .sram_oe(s2_oe), .sram_we(s2_we), .sram_addr(s2_addr),
    .sram_wdata(s2_wdata), .sram_rdata(s2_rdata),
    .busy(s2_busy), .done(s2_done), .ovf(s2_ovf)
  );

  // SRAM models; the bench preloads both through tb_we
  logic [7:0] mem1 [32];
  logic [7:0] mem2 [32];
  logic [7:0] rpipe1, p2_0, p2_1, p2_2;

  always @(posedge clk) begin
    if (tb_we) mem1[tb_a] <= tb_d;
    else if (sram_ce && sram_we) mem1[sram_addr] <= sram_wdata;
    if (sram_ce && sram_oe) rpipe1 <= mem1[sram_addr];
  end
  assign sram_rdata = rpipe1;

  always @(posedge clk) begin
    if (tb_we) mem2[tb_a] <= tb_d;
    else if (s2_ce && s2_we) mem2[s2_addr] <= s2_wdata;
    p2_0 <= (s2_ce && s2_oe) ? mem2[s2_addr] : 8'h00;
    p2_1 <= p2_0;
    p2_2 <= p2_1;
  end
  assign s2_rdata = p2_2;

  // Monotonic event counters and address logs, sampled mid-cycle
  int busy_cnt = 0, done_cnt = 0, we_cnt = 0, ovl_cnt = 0, xa_cnt = 0;
  int rd_n = 0, wr_n = 0, busy2_cnt = 0;
  logic [4:0] rd_log [256];
  logic [4:0] wr_log [256];

  always @(negedge clk) begin
    if (busy) busy_cnt <= busy_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (sram_we) we_cnt <= we_cnt + 1;
    if (sram_oe && sram_we) ovl_cnt <= ovl_cnt + 1;
    if ($isunknown(sram_addr)) xa_cnt <= xa_cnt + 1;
    if (sram_ce && sram_oe) begin
      rd_log[rd_n[7:0]] <= sram_addr;
      rd_n <= rd_n + 1;
    end
    if (sram_ce && sram_we) begin
      wr_log[wr_n[7:0]] <= sram_addr;
      wr_n <= wr_n + 1;
    end
    if (s2_busy) busy2_cnt <= busy2_cnt + 1;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [4:0] a, input logic [7:0] d);
    tb_a  = a;
    tb_d  = d;
    tb_we = 1'b1;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  task automatic go(input logic [4:0] s, input logic [4:0] d, input logic [2:0] m);
    src_base = s;
    dst_base = d;
    op_mode  = m;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns the busy-cycle index at which done was seen; leaves bench at posedge+1
  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) check_eq({tag, " timeout"}, 32'd0, 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  int b0, d0, w0, r0, n, idx;
  logic [4:0] exp_rd [6];
  logic [4:0] exp_wr [3];

  initial begin
    start = 0; abort = 0; src_base = 0; dst_base = 0; op_mode = 0;
    s2_start = 0; s2_src = 0; s2_dst = 0; s2_mode = 0;
    tb_we = 0; tb_a = 0; tb_d = 0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst busy/done/ovf", {29'd0, busy, done, ovf}, 32'd0);
    check_eq("rst strobes", {29'd0, sram_ce, sram_oe, sram_we}, 32'd0);
    check_eq("rst addr/wdata", {19'd0, sram_addr, sram_wdata}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // 1: rotating functions ADD, SUB, AND
    poke(0, 8'd10); poke(1, 8'd3); poke(2, 8'd7); poke(3, 8'd2); poke(4, 8'hF0); poke(5, 8'h3C);
    b0 = busy_cnt; d0 = done_cnt;
    go(0, 8, 3'b100);
    wait_done("t1", n);
    check_eq("t1 done latency", n, 19);
    check_eq("t1 busy cycles", busy_cnt - b0, 19);
    check_eq("t1 done pulses", done_cnt - d0, 1);
    check_eq("t1 mem8", mem1[8], 8'd13);
    check_eq("t1 mem9", mem1[9], 8'd5);
    check_eq("t1 mem10", mem1[10], 8'h30);
    check_eq("t1 ovf", ovf, 0);

    // 2: fixed ADD then fixed SUB, both overflow
    poke(0, 8'hFF); poke(1, 8'h01); poke(2, 8'h05); poke(3, 8'h09); poke(4, 8'hAA); poke(5, 8'h0F);
    go(0, 12, 3'b000);
    wait_done("t2a", n);
    check_eq("t2 add mem12", mem1[12], 8'h00);
    check_eq("t2 add mem13", mem1[13], 8'h0E);
    check_eq("t2 add mem14", mem1[14], 8'hB9);
    check_eq("t2 add ovf", ovf, 1);
    go(0, 12, 3'b001);
    wait_done("t2b", n);
    check_eq("t2 sub mem12", mem1[12], 8'hFE);
    check_eq("t2 sub mem13", mem1[13], 8'hFC);
    check_eq("t2 sub mem14", mem1[14], 8'h9B);
    check_eq("t2 sub ovf", ovf, 1);

    // 3: address wrap with overlapping src/dst, fixed XOR
    poke(30, 8'h11); poke(31, 8'h22); poke(0, 8'h33); poke(1, 8'h44); poke(2, 8'h55); poke(3, 8'h66);
    exp_rd = '{5'd30, 5'd31, 5'd0, 5'd1, 5'd2, 5'd3};
    exp_wr = '{5'd31, 5'd0, 5'd1};
    r0 = rd_n; w0 = wr_n;
    go(30, 31, 3'b011);
    wait_done("t3", n);
    check_eq("t3 read count", rd_n - r0, 6);
    check_eq("t3 write count", wr_n - w0, 3);
    for (int j = 0; j < 6; j++) begin
      idx = r0 + j;
      check_eq($sformatf("t3 rd addr %0d", j), rd_log[idx[7:0]], exp_rd[j]);
    end
    for (int j = 0; j < 3; j++) begin
      idx = w0 + j;
      check_eq($sformatf("t3 wr addr %0d", j), wr_log[idx[7:0]], exp_wr[j]);
    end
    check_eq("t3 mem31", mem1[31], 8'h33);
    check_eq("t3 mem0", mem1[0], 8'h77);
    check_eq("t3 mem1", mem1[1], 8'h33);
    check_eq("t3 ovf cleared", ovf, 0);
    check_eq("t3 addr X", xa_cnt, 0);

    // 4: abort in 5th busy cycle, then a clean rerun
    poke(0, 8'd10); poke(1, 8'd3); poke(2, 8'd7); poke(3, 8'd2); poke(4, 8'hF0); poke(5, 8'h3C);
    poke(8, 8'h00); poke(9, 8'h00); poke(10, 8'h00);
    w0 = we_cnt; d0 = done_cnt;
    go(0, 8, 3'b100);
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check_eq("t4 busy after abort", busy, 0);
    repeat (5) @(posedge clk);
    #1;
    check_eq("t4 no we", we_cnt - w0, 0);
    check_eq("t4 no done", done_cnt - d0, 0);
    check_eq("t4 mem8 untouched", mem1[8], 8'h00);
    go(0, 8, 3'b100);
    wait_done("t4 rerun", n);
    check_eq("t4 rerun latency", n, 19);
    check_eq("t4 rerun mem8", mem1[8], 8'd13);
    check_eq("t4 rerun mem9", mem1[9], 8'd5);
    check_eq("t4 rerun mem10", mem1[10], 8'h30);

    // 5a: start pulsed while busy is ignored
    d0 = done_cnt;
    go(0, 16, 3'b100);
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("t5a", n);
    repeat (25) @(posedge clk);
    #1;
    check_eq("t5a single done", done_cnt - d0, 1);
    check_eq("t5a mem18", mem1[18], 8'h30);

    // 5b: async reset during the first WR
    poke(20, 8'hEE); poke(21, 8'hEE);
    go(0, 20, 3'b100);
    n = 0;
    while (!sram_we && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("t5b we reached", sram_we, 1);
    #2 reset = 1'b1;
    #1;
    check_eq("t5b we drops", sram_we, 0);
    check_eq("t5b ce drops", sram_ce, 0);
    check_eq("t5b busy drops", busy, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("t5b mem20 unchanged", mem1[20], 8'hEE);
    check_eq("t5b mem21 unchanged", mem1[21], 8'hEE);
    check_eq("t5b idle", busy, 0);
    check_eq("oe/we overlap", ovl_cnt, 0);

    // 6: SRAM_LAT=3, N_OPS=4 instance
    poke(0, 8'd1); poke(1, 8'd2); poke(2, 8'd3); poke(3, 8'd4);
    poke(4, 8'd5); poke(5, 8'd6); poke(6, 8'd7); poke(7, 8'd8);
    b0 = busy2_cnt;
    s2_src = 0; s2_dst = 16; s2_mode = 3'b100; s2_start = 1'b1;
    @(posedge clk);
    #1 s2_start = 1'b0;
    n = 0;
    while (!s2_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("t6 done seen", s2_done, 1);
    check_eq("t6 done latency", n, 41);
    repeat (2) @(posedge clk);
    #1;
    check_eq("t6 busy cycles", busy2_cnt - b0, 41);
    check_eq("t6 mem16", mem2[16], 8'h03);
    check_eq("t6 mem17", mem2[17], 8'hFF);
    check_eq("t6 mem18", mem2[18], 8'h04);
    check_eq("t6 mem19", mem2[19], 8'h0F);
    check_eq("t6 ovf", s2_ovf, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
